// File: rtl/octave_pkg.sv
// rtl/octave_pkg.sv - shared constants and types for the octave stepper
//
// Purpose: select command encoding, the default octave-number width and the
// octave typedef used by octave and octave_step.
package octave_pkg;

  localparam int OCT_W_DEFAULT = 3;

  localparam logic [1:0] SEL_HOLD    = 2'd0;
  localparam logic [1:0] SEL_UP      = 2'd1;
  localparam logic [1:0] SEL_DOWN    = 2'd2;
  localparam logic [1:0] SEL_DEFAULT = 2'd3;

  typedef logic [OCT_W_DEFAULT-1:0] octave_t;

endpackage

// File: rtl/octave_step.sv
// rtl/octave_step.sv - combinational clamp, step and saturate/wrap of an octave number
//
// Purpose: clamps the present octave into [MIN_OCT, MAX_OCT] and applies the
// select command. Config macro OCTAVE_WRAP_EN: when defined, stepping past
// either limit wraps to the opposite limit; otherwise it saturates.
// Ports:
//   select_i  [1:0]       command (hold / up / down / load default)
//   current_i [OCT_W-1:0] present octave, unsigned, may be out of range
//   next_o    [OCT_W-1:0] next octave, always within limits
module octave_step
  import octave_pkg::*;
#(
  parameter int OCT_W   = OCT_W_DEFAULT,
  parameter int MIN_OCT = 0,
  parameter int MAX_OCT = 7,
  parameter int DEF_OCT = 4
) (
  input  logic [1:0]       select_i,
  input  logic [OCT_W-1:0] current_i,
  output logic [OCT_W-1:0] next_o
);

  // Clamp compares run one bit wider so MAX_OCT = 2**OCT_W-1 is safe.
  localparam logic [OCT_W:0]   MIN_W = MIN_OCT[OCT_W:0];
  localparam logic [OCT_W:0]   MAX_W = MAX_OCT[OCT_W:0];
  localparam logic [OCT_W-1:0] MIN_N = MIN_OCT[OCT_W-1:0];
  localparam logic [OCT_W-1:0] MAX_N = MAX_OCT[OCT_W-1:0];
  localparam logic [OCT_W-1:0] DEF_N = DEF_OCT[OCT_W-1:0];

`ifdef OCTAVE_WRAP_EN
  localparam logic [OCT_W-1:0] PAST_TOP    = MIN_N;
  localparam logic [OCT_W-1:0] PAST_BOTTOM = MAX_N;
`else
  localparam logic [OCT_W-1:0] PAST_TOP    = MAX_N;
  localparam logic [OCT_W-1:0] PAST_BOTTOM = MIN_N;
`endif

  logic [OCT_W:0]   cur_w;
  logic [OCT_W:0]   cur_c;
  logic [OCT_W-1:0] nxt;

  always_comb begin
    cur_w = {1'b0, current_i};
    cur_c = cur_w;
    if (cur_w > MAX_W) begin
      cur_c = MAX_W;
    end else if (cur_w < MIN_W) begin
      cur_c = MIN_W;
    end

    // cur_c is within limits here, so its low bits hold the whole value and
    // +1 / -1 below cannot leave the OCT_W range.
    nxt = cur_c[OCT_W-1:0];
    case (select_i)
      SEL_UP: begin
        if (cur_c == MAX_W) nxt = PAST_TOP;
        else                nxt = cur_c[OCT_W-1:0] + 1'b1;
      end
      SEL_DOWN: begin
        if (cur_c == MIN_W) nxt = PAST_BOTTOM;
        else                nxt = cur_c[OCT_W-1:0] - 1'b1;
      end
      SEL_DEFAULT: nxt = DEF_N;
      default:     nxt = cur_c[OCT_W-1:0];
    endcase
  end

  assign next_o = nxt;

endmodule

// File: rtl/octave.sv
// rtl/octave.sv - registered octave-selection stepper with limit and change flags
//
// Purpose: registers the next octave computed from current/select each clock,
// plus at_max / at_min / changed flags derived from the newly registered value.
// Stateless apart from these registers; repeated stepping needs the parent to
// feed out back into current. Config macro OCTAVE_WRAP_EN (see octave_step).
// Ports:
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   select   [1:0] 0 hold, 1 up, 2 down, 3 load default
//   current  [OCT_W-1:0] present octave
//   out      [OCT_W-1:0] registered next octave
//   at_max   registered, out == MAX_OCT
//   at_min   registered, out == MIN_OCT
//   changed  registered, out differs from its previous value
module octave
  import octave_pkg::*;
#(
  parameter int OCT_W   = OCT_W_DEFAULT,
  parameter int MIN_OCT = 0,
  parameter int MAX_OCT = 7,
  parameter int DEF_OCT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [OCT_W-1:0] current,
  output logic [OCT_W-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             changed
);

  if (OCT_W < 1 || MIN_OCT < 0 || MIN_OCT > DEF_OCT || DEF_OCT > MAX_OCT ||
      MAX_OCT >= (1 << OCT_W)) begin : g_bad_params
    $error("octave: need 0 <= MIN_OCT <= DEF_OCT <= MAX_OCT < 2**OCT_W");
  end

  localparam logic [OCT_W-1:0] MIN_N = MIN_OCT[OCT_W-1:0];
  localparam logic [OCT_W-1:0] MAX_N = MAX_OCT[OCT_W-1:0];
  localparam logic [OCT_W-1:0] DEF_N = DEF_OCT[OCT_W-1:0];

  logic [OCT_W-1:0] out_d, out_q;
  logic             at_max_d, at_max_q;
  logic             at_min_d, at_min_q;
  logic             changed_d, changed_q;

  octave_step #(
    .OCT_W  (OCT_W),
    .MIN_OCT(MIN_OCT),
    .MAX_OCT(MAX_OCT),
    .DEF_OCT(DEF_OCT)
  ) u_step (
    .select_i (select),
    .current_i(current),
    .next_o   (out_d)
  );

  always_comb begin
    at_max_d  = (out_d == MAX_N);
    at_min_d  = (out_d == MIN_N);
    changed_d = (out_d != out_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= DEF_N;
      at_max_q  <= (DEF_OCT == MAX_OCT);
      at_min_q  <= (DEF_OCT == MIN_OCT);
      changed_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
      changed_q <= changed_d;
    end
  end

  assign out     = out_q;
  assign at_max  = at_max_q;
  assign at_min  = at_min_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_octave.sv
// tb/tb_octave.sv - self-checking bench for octave (default and OCTAVE_WRAP_EN builds)
module tb_octave;
  import octave_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] select;
  octave_t    current;

  octave_t    out_a, out_b;
  logic       amax_a, amin_a, chg_a;
  logic       amax_b, amin_b, chg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default-parameter instance.
  octave dut (
    .clk(clk), .rst_n(rst_n), .select(select), .current(current),
    .out(out_a), .at_max(amax_a), .at_min(amin_a), .changed(chg_a)
  );

  // Narrowed limits so that clamping of out-of-range current is exercised.
  octave #(.OCT_W(3), .MIN_OCT(1), .MAX_OCT(6), .DEF_OCT(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .select(select), .current(current),
    .out(out_b), .at_max(amax_b), .at_min(amin_b), .changed(chg_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference rule: clamp, then step with saturate (or wrap) at the limits.
  function automatic int ref_next(int cur, int sel, int mn, int mx, int df);
    int c;
    c = (cur < mn) ? mn : ((cur > mx) ? mx : cur);
    case (sel)
      0: return c;
`ifdef OCTAVE_WRAP_EN
      1: return (c == mx) ? mn : c + 1;
      2: return (c == mn) ? mx : c - 1;
`else
      1: return (c == mx) ? mx : c + 1;
      2: return (c == mn) ? mn : c - 1;
`endif
      default: return df;
    endcase
  endfunction

  int mo_a, mo_b;

  // Apply one cycle of stimulus, sample 1 time unit after the edge, and
  // check both instances against the reference model.
  task automatic tick(input bit r, input int s, input int c);
    int na, nb;
    rst_n   = r;
    select  = 2'(s);
    current = octave_t'(c);
    @(posedge clk);
    #1;
    na = r ? ref_next(c, s, 0, 7, 4) : 4;
    nb = r ? ref_next(c, s, 1, 6, 3) : 3;
    chk("model_out",     int'(out_a), na);
    chk("model_at_max",  int'(amax_a), int'(na == 7));
    chk("model_at_min",  int'(amin_a), int'(na == 0));
    chk("model_changed", int'(chg_a), r ? int'(na != mo_a) : 0);
    chk("clamp_out",     int'(out_b), nb);
    chk("clamp_at_max",  int'(amax_b), int'(nb == 6));
    chk("clamp_at_min",  int'(amin_b), int'(nb == 1));
    chk("clamp_changed", int'(chg_b), r ? int'(nb != mo_b) : 0);
    mo_a = na;
    mo_b = nb;
  endtask

  typedef struct {
    bit r;
    int sel;
    int cur;
    int e_out;
    int e_max;
    int e_min;
    int e_chg;
  } vec_t;

  vec_t vecs[10];
  int   up_exp[4];
  int   dn_exp[8];
  int   pulses;

  initial begin
    rst_n = 1'b0; select = 2'd0; current = '0;
    mo_a = 4; mo_b = 3;

    vecs[0] = '{0, 1, 0, 4, 0, 0, 0};  // reset overrides select
    vecs[1] = '{1, 0, 2, 2, 0, 0, 1};  // hold
    vecs[2] = '{1, 0, 2, 2, 0, 0, 0};
    vecs[3] = '{1, 3, 6, 4, 0, 0, 1};  // load default
    vecs[4] = '{1, 3, 6, 4, 0, 0, 0};
`ifdef OCTAVE_WRAP_EN
    vecs[5] = '{1, 1, 7, 0, 0, 1, 1};  // up at top wraps
    vecs[6] = '{1, 2, 0, 7, 1, 0, 1};  // down at bottom wraps
`else
    vecs[5] = '{1, 1, 7, 7, 1, 0, 1};  // up at top saturates
    vecs[6] = '{1, 2, 0, 0, 0, 1, 1};  // down at bottom saturates
`endif
    vecs[7] = '{1, 1, 0, 1, 0, 0, 1};
    vecs[8] = '{0, 2, 5, 4, 0, 0, 0};  // reset mid-sequence
    vecs[9] = '{1, 2, 5, 4, 0, 0, 0};  // first edge after reset computes 5-1

    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].r, vecs[i].sel, vecs[i].cur);
      chk($sformatf("vec%0d_out", i), int'(out_a), vecs[i].e_out);
      chk($sformatf("vec%0d_at_max", i), int'(amax_a), vecs[i].e_max);
      chk($sformatf("vec%0d_at_min", i), int'(amin_a), vecs[i].e_min);
      chk($sformatf("vec%0d_changed", i), int'(chg_a), vecs[i].e_chg);
    end

    // Up with external feedback, 5-cycle windows.
    up_exp = '{5, 6, 7, 7};
`ifdef OCTAVE_WRAP_EN
    up_exp[3] = 0;
`endif
    begin
      int cur;
      cur = 4;
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 5; k++) begin
          tick(1, 1, cur);
`ifndef OCTAVE_WRAP_EN
          if (w == 3) chk("up_w4_changed", int'(chg_a), 0);
`endif
        end
        chk($sformatf("up_w%0d_out", w + 1), int'(out_a), up_exp[w]);
        chk($sformatf("up_w%0d_at_max", w + 1), int'(amax_a), int'(up_exp[w] == 7));
        cur = up_exp[w];
      end
    end

    // Down with external feedback from 7.
    dn_exp = '{6, 5, 4, 3, 2, 1, 0, 0};
`ifdef OCTAVE_WRAP_EN
    dn_exp[7] = 7;
`endif
    begin
      int cur;
      cur = 7;
      for (int w = 0; w < 8; w++) begin
        for (int k = 0; k < 5; k++) tick(1, 2, cur);
        chk($sformatf("dn_w%0d_out", w + 1), int'(out_a), dn_exp[w]);
        chk($sformatf("dn_w%0d_at_min", w + 1), int'(amin_a), int'(dn_exp[w] == 0));
        cur = dn_exp[w];
      end
    end

    // Constant inputs do not keep counting; changed pulses once.
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 1, 3);
      chk("stable_out", int'(out_a), 4);
      if (chg_a) pulses++;
    end
    chk("stable_pulses", pulses, 1);

    // Randomized stimulus with occasional resets.
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(15) != 0), int'($urandom_range(3)), int'($urandom_range(7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/octave.md
# octave

Registered octave-selection stepper for the electric-piano datapath. Each clock it takes the currently active octave number and a 2-bit command from the octave buttons, and produces the next octave number, saturating at configurable limits. The output feeds the note-frequency divider stage and is normally fed back by the parent as `current`.

## Interface
- `OCT_W`, 3: width of octave numbers.
- `MIN_OCT`, 0: lowest legal octave.
- `MAX_OCT`, 7: highest legal octave; requires `MIN_OCT <= DEF_OCT <= MAX_OCT < 2**OCT_W`.
- `DEF_OCT`, 4: reset and default octave.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `select` in 2: command. 0 = hold, 1 = up, 2 = down, 3 = load default.
- `current` in `OCT_W`: present octave, unsigned.
- `out` out `OCT_W`: registered next octave.
- `at_max` out 1: registered; 1 when `out == MAX_OCT`.
- `at_min` out 1: registered; 1 when `out == MIN_OCT`.
- `changed` out 1: registered; 1 for the cycle after a clock edge where the new `out` differs from its previous value.

## Operation
- Clamp input first: `cur_c = max(MIN_OCT, min(MAX_OCT, current))`.
- Next value:
  - hold: `cur_c`
  - up: `cur_c + 1`, or `MAX_OCT` if `cur_c == MAX_OCT`
  - down: `cur_c - 1`, or `MIN_OCT` if `cur_c == MIN_OCT`
  - default: `DEF_OCT`
- Arithmetic is done at `OCT_W+1` bits, so `MAX_OCT = 2**OCT_W - 1` never overflows.
- The block is stateless apart from its output registers. The step is a function of `current`, not of `out`.
  - Holding `select = 1` with `current` constant yields a constant `out = current + 1`. It does not keep counting.
  - Repeated stepping occurs only through external feedback of `out` into `current`.
- `at_max`, `at_min` and `changed` derive from the newly registered value.

## Timing
- Latency: 1 cycle from `select`/`current` to `out` and flags. No handshake; a new command is accepted every cycle.
- Reset (`rst_n = 0` at a rising edge) sets:
  - `out = DEF_OCT`
  - `at_max = (DEF_OCT == MAX_OCT)`
  - `at_min = (DEF_OCT == MIN_OCT)`
  - `changed = 0`
- Reset overrides `select`.
- Reset asserted mid-sequence takes effect at that edge. The first edge after deassertion computes normally from the inputs.
- Out-of-range `current` with hold: `out` becomes the clamped value, and `changed` is set if that differs from the previous `out`.

## Configuration
- `OCTAVE_WRAP_EN` defined:
  - up at `MAX_OCT` gives `MIN_OCT`.
  - down at `MIN_OCT` gives `MAX_OCT`.
  - Flags are unchanged in meaning.
- Not defined: saturating behaviour as above. This is the default build.

## Structure
- `octave_pkg` holds:
  - select encoding constants `SEL_HOLD = 2'd0`, `SEL_UP = 2'd1`, `SEL_DOWN = 2'd2`, `SEL_DEFAULT = 2'd3`
  - the `OCT_W` default
  - the octave typedef
- Sub-module `octave_step` is purely combinational: clamp, step and saturate/wrap. It is instantiated once by `octave`, which holds the output registers and flag logic.
- Include parameter-legality elaboration checks.

## Test plan
- Reset: assert `rst_n = 0` for one edge with `select = 1`, `current = 0` -> `out = 4`, `at_max = 0`, `at_min = 0`, `changed = 0`.
- Up with feedback: start `current = 4`, `select = 1`; after each 5-cycle window set `current = out`.
  - Successive `out` values: 5, 6, 7, 7.
  - `at_max = 1` from the third window on.
  - `changed = 0` during the fourth window.
- Down with feedback: from `current = 7`, `select = 2`, seven feedback windows -> 6, 5, 4, 3, 2, 1, 0. An eighth window gives 0 with `at_min = 1`.
- Hold and default:
  - `current = 2`, `select = 0` -> `out = 2`.
  - `select = 3` with `current = 6` -> `out = 4`, `changed = 1` for one cycle.
- Constant-input stability: `current = 3`, `select = 1` held 10 cycles -> `out` stays at 4, and `changed` pulses exactly once.
- `OCTAVE_WRAP_EN` build: `current = 7`, `select = 1` -> `out = 0`. Then `current = 0`, `select = 2` -> `out = 7`.
